instr_word_decoder: RTL and testbench

//  Decodes the 16-bit instruction word stream that the CPU emits on instrWord. Recovers

---
 rtl/instr_word_decoder.sv | 130 +++++++++++++
 tb/tb_instr_word_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_word_decoder.sv
// Instruction word stream decoder: splits opcode/AM/operand and fuses the
// two-word extended form into one decoded instruction held in a single output slot.
module instr_word_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_opcode,
    output logic             out_am,
    output logic [15:0]      out_operand,
    output logic             out_illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  hold_op;
    logic        hold_am;

    logic        accept;
    logic        handoff;
    logic        load;
    logic        hold_en;
    logic [2:0]  ld_op;
    logic        ld_am;
    logic [15:0] ld_operand;

    // Slot space exists when it is empty or being drained this cycle.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        hold_en    = 1'b0;
        ld_op      = in_word[15:13];
        ld_am      = in_word[12];
        ld_operand = {{4{in_word[11]}}, in_word[11:0]};
        case (state)
            S_OP: begin
                if (accept) begin
                    if (in_word[12]) begin
                        hold_en   = 1'b1;
                        state_nxt = S_IMM;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_IMM: begin
                // Extension word: the whole word is operand, upper bits not decoded.
                if (accept) begin
                    load       = 1'b1;
                    ld_op      = hold_op;
                    ld_am      = hold_am;
                    ld_operand = in_word;
                    state_nxt  = S_OP;
                end
            end
            default: state_nxt = S_OP;
        endcase
        if (flush) state_nxt = S_OP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_OP;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_op <= 3'd0;
            hold_am <= 1'b0;
        end else if (flush) begin
            hold_op <= 3'd0;
            hold_am <= 1'b0;
        end else if (hold_en) begin
            hold_op <= in_word[15:13];
            hold_am <= in_word[12];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_opcode  <= 3'd0;
            out_am      <= 1'b0;
            out_operand <= 16'd0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_opcode  <= 3'd0;
            out_am      <= 1'b0;
            out_operand <= 16'd0;
            out_illegal <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_opcode  <= ld_op;
            out_am      <= ld_am;
            out_operand <= ld_operand;
            out_illegal <= (ld_op == 3'b111) && ld_am;
        end else if (handoff) begin
            out_valid <= 1'b0;
        end
    end

    // Counts every hand-off, including one that coincides with a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (handoff) begin
            instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_word_decoder.sv
// Self-checking bench for instr_word_decoder: directed cases plus random traffic
// checked against a transaction-level reference model.
module tb_instr_word_decoder;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_word;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_opcode;
    logic             out_am;
    logic [15:0]      out_operand;
    logic             out_illegal;
    logic [CNT_W-1:0] instr_count;

    instr_word_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_am(out_am), .out_operand(out_operand),
        .out_illegal(out_illegal), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: pending first word of an extended instruction plus the slot.
    bit          m_pend;
    int          m_pend_op;
    bit          m_valid;
    int          m_op;
    int          m_am;
    int          m_operand;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_pend_op = 0; m_valid = 0;
        m_op = 0; m_am = 0; m_operand = 0; m_cnt = 0;
    endtask

    function automatic int sext12(input logic [15:0] w);
        int v;
        v = int'(w[11:0]);
        if (v >= 2048) v = v - 4096;
        return v & 16'hFFFF;
    endfunction

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("instr_count", 32'(instr_count), 32'(m_cnt % (1 << CNT_W)));
        if (m_valid) begin
            chk("out_opcode", 32'(out_opcode), 32'(m_op));
            chk("out_am", 32'(out_am), 32'(m_am));
            chk("out_operand", 32'(out_operand), 32'(m_operand));
            chk("out_illegal", {31'd0, out_illegal}, (m_op == 7 && m_am == 1) ? 32'd1 : 32'd0);
        end
    endtask

    // One clock cycle: drive at negedge, check ready, advance model, check after the edge.
    task automatic step(input logic v, input logic [15:0] w, input logic ordy, input logic fl);
        bit exp_rdy, acc, ho;
        in_valid = v; in_word = w; out_ready = ordy; flush = fl;
        #1;
        exp_rdy = !fl && (!m_valid || ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        ho  = m_valid && ordy;
        if (ho) m_cnt++;
        if (fl) begin
            m_pend = 0; m_valid = 0;
        end else if (acc && m_pend) begin
            m_valid = 1; m_op = m_pend_op; m_am = 1; m_operand = int'(w);
            m_pend = 0;
        end else if (acc && w[12]) begin
            m_pend = 1; m_pend_op = int'(w[15:13]);
            if (ho) m_valid = 0;
        end else if (acc) begin
            m_valid = 1; m_op = int'(w[15:13]); m_am = 0; m_operand = sext12(w);
        end else if (ho) begin
            m_valid = 0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, ordy, 1'b0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = 16'h0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_opcode", 32'(out_opcode), 32'd0);
        chk("reset_operand", 32'(out_operand), 32'd0);
        chk("reset_illegal", {31'd0, out_illegal}, 32'd0);
        reset = 1'b0;
        #1 chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Short instruction, sign extension.
        step(1'b1, 16'h2ABC, 1'b1, 1'b0);
        chk("t1_operand", 32'(out_operand), 32'h0000FABC);
        idle(1, 1'b1);
        chk("t1_count", 32'(instr_count), 32'd1);

        // Extended instruction, back-to-back and with a 3-cycle gap.
        step(1'b1, 16'hB000, 1'b1, 1'b0);
        chk("t2_no_early_out", {31'd0, out_valid}, 32'd0);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("t2_operand", 32'(out_operand), 32'h1234);
        step(1'b1, 16'hB000, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("t2_gap_opcode", 32'(out_opcode), 32'd5);
        idle(1, 1'b1);

        // Back-pressure.
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 16'h4002, 1'b0, 1'b0);
        chk("t3_hold_operand", 32'(out_operand), 32'd1);
        step(1'b1, 16'h4002, 1'b1, 1'b0);
        chk("t3_next_operand", 32'(out_operand), 32'd2);
        idle(1, 1'b1);

        // Reserved encoding still delivered and counted.
        step(1'b1, 16'hF000, 1'b1, 1'b0);
        step(1'b1, 16'hFFFF, 1'b1, 1'b0);
        chk("t4_illegal", {31'd0, out_illegal}, 32'd1);
        idle(1, 1'b1);

        // Flush drops the partial instruction.
        step(1'b1, 16'h9000, 1'b1, 1'b0);
        step(1'b1, 16'h1111, 1'b1, 1'b1);
        step(1'b1, 16'h2005, 1'b1, 1'b0);
        chk("t5_am", {31'd0, out_am}, 32'd0);
        chk("t5_operand", 32'(out_operand), 32'd5);
        idle(1, 1'b1);

        // Counter wrap after 256 hand-offs from reset.
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 16'(i & 16'h0FFF), 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("t6_wrap", 32'(instr_count), 32'd0);

        // Reset while in S_IMM: next word is an opcode word.
        step(1'b1, 16'hD000, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 16'h6007, 1'b1, 1'b0);
        chk("t6_post_reset_op", 32'(out_opcode), 32'd3);
        idle(1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:13] = 3'b111;
            step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        idle(2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
